// File: rtl/sum_pkg.sv
// Shared types and default sizes for the sum_collect block.
package sum_pkg;

  localparam int SUM_N = 1024;
  localparam int SUM_W = 2;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } sum_state_e;

endpackage

// File: rtl/sum_chunk_cnt.sv
// Chunk index counter: counts accepted chunks 0..CC-1 and wraps, flagging the last slot.
module sum_chunk_cnt #(
  parameter  int CC    = 512,
  localparam int IDX_W = (CC > 1) ? $clog2(CC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  assign idx  = idx_q;
  assign last = (idx_q == IDX_W'(CC - 1));

  always_comb begin
    idx_d = idx_q;
    if (inc) begin
      idx_d = last ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/sum_collect.sv
// Assembles W-bit serial-adder sum chunks (LSB chunk first) into an N-bit word with a valid/ready output.
// Optional registered parity output enabled by defining SUM_COLLECT_PARITY_EN.
module sum_collect
  import sum_pkg::*;
#(
  parameter int N = SUM_N,
  parameter int W = SUM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] c_in,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef SUM_COLLECT_PARITY_EN
  ,
  output logic         out_parity
`endif
);

  localparam int CC    = N / W;
  localparam int IDX_W = (CC > 1) ? $clog2(CC) : 1;

  sum_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     data_q, data_d;
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic             last;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign accept    = in_valid && in_ready_q;

  sum_chunk_cnt #(
    .CC (CC)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .idx  (idx),
    .last (last)
  );

`ifdef SUM_COLLECT_PARITY_EN
  logic         parity_q, parity_d;
  logic [W-1:0] old_chunk;
  assign out_parity = parity_q;
`endif

  // Only the chunk slot selected by idx is overwritten; unwritten slots keep prior contents.
  always_comb begin
    data_d = data_q;
`ifdef SUM_COLLECT_PARITY_EN
    old_chunk = '0;
`endif
    for (int k = 0; k < CC; k++) begin
      if (idx == IDX_W'(k)) begin
`ifdef SUM_COLLECT_PARITY_EN
        old_chunk = data_q[k*W +: W];
`endif
        if (accept) begin
          data_d[k*W +: W] = c_in;
        end
      end
    end
`ifdef SUM_COLLECT_PARITY_EN
    // Replacing a slot flips parity by the XOR of old and new chunk bits.
    parity_d = accept ? (parity_q ^ (^(old_chunk ^ c_in))) : parity_q;
`endif
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      COLLECT: begin
        if (accept && last) begin
          state_d     = HOLD;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = COLLECT;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = COLLECT;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= COLLECT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_q      <= '0;
`ifdef SUM_COLLECT_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
`ifdef SUM_COLLECT_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: doc/sum_collect.md
SUM_COLLECT -- requirements
Module: sum_collect

Interface
REQ-001 SHALL have parameter N, default 1024: result word width in bits.
REQ-002 SHALL have parameter W, default 2: chunk width per cycle; N SHALL be a multiple of W; CC = N/W chunks per word.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-004 SHALL have port rst  input  1  synchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  chunk on c_in is valid this cycle.
REQ-006 SHALL have port c_in  input  W  sum chunk from the upstream serial adder, LSB chunk first.
REQ-007 SHALL have port in_ready  output  1  block accepts a chunk this cycle.
REQ-008 SHALL have port out_data  output  N  assembled sum word.
REQ-009 SHALL have port out_valid  output  1  out_data holds a complete word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL have port out_parity  output  1  XOR of all bits of out_data (present only with SUM_COLLECT_PARITY_EN).

Function
REQ-012 SHALL implement FSM states COLLECT and HOLD; COLLECT is the reset state.
REQ-013 In COLLECT, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-014 A chunk SHALL be accepted when in_valid && in_ready; chunk k (k = 0..CC-1) SHALL be written to out_data[k*W +: W].
REQ-015 Chunk index counter SHALL range 0..CC-1, increment per accepted chunk, and wrap to 0 after CC-1 is accepted.
REQ-016 Acceptance of chunk CC-1 SHALL move the FSM to HOLD on the next edge; out_valid SHALL be 1 the cycle after the last chunk is accepted (latency 1).
REQ-017 In HOLD, out_data SHALL remain stable until out_valid && out_ready; that handshake SHALL return the FSM to COLLECT on the next edge.
REQ-018 in_valid SHALL be ignored while in HOLD (no write, no count change); upstream stalls on in_ready = 0.
REQ-019 A handshake and in_valid in the same HOLD cycle SHALL not accept the chunk; the first chunk of the next word is accepted no earlier than the following cycle.
REQ-020 in_valid = 0 in COLLECT SHALL hold counter and partial data unchanged (gaps allowed).
REQ-021 With W = N (CC = 1) every accepted chunk SHALL go directly to HOLD.
REQ-022 out_data bits of chunks not yet written for the current word SHALL retain prior values; only out_valid qualifies out_data.

Reset
REQ-023 rst = 0 at a rising clk edge SHALL force: FSM COLLECT, counter 0, out_data all 0, out_valid 0, in_ready 1 after release, out_parity 0.
REQ-024 Reset mid-word or in HOLD SHALL discard the partial or held word; no out_valid SHALL follow from pre-reset chunks.

Configuration
REQ-025 With macro SUM_COLLECT_PARITY_EN defined, out_parity SHALL exist and be registered, valid together with out_valid, equal to XOR-reduce of out_data, updated incrementally per accepted chunk.
REQ-026 Without SUM_COLLECT_PARITY_EN, out_parity port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package sum_pkg SHALL hold the FSM state typedef (COLLECT, HOLD) and default constants SUM_N = 1024, SUM_W = 2.
REQ-028 Chunk counter SHALL be a sub-module sum_chunk_cnt (parameter CC; inputs clk, rst, inc; outputs idx, last).

Verification (N=8, W=2, CC=4)
REQ-029 Reset, then chunks 2'b01,2'b10,2'b11,2'b00 with in_valid=1 each cycle -> out_valid=1 one cycle after 4th chunk, out_data=8'h39.
REQ-030 Same chunks with in_valid=0 gaps of 1..3 cycles -> identical out_data=8'h39, no early out_valid.
REQ-031 out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, out_data stable 8'h39, counter unchanged; out_ready=1 -> COLLECT next cycle.
REQ-032 rst=0 after 2 chunks, then 4 chunks 2'b11 -> out_data=8'hFF, no word from pre-reset chunks.
REQ-033 Two back-to-back words 8'h39 then 8'hC6 with out_ready=1 -> two out_valid pulses, second 8'hC6; out_parity=0 for both when SUM_COLLECT_PARITY_EN defined.
